// File: rtl/plot_scheduler.sv
// plot_scheduler: shares the VGA pixel write port between game-object requesters, running an
// erase pass (old rect, BG colour) then a draw pass (new rect) per job. PLOT_RR_EN selects round-robin.
`timescale 1ns/1ps
module plot_scheduler #(
   parameter int         NREQ   = 3,
   parameter int         MAX_X  = 159,
   parameter int         MAX_Y  = 119,
   parameter logic [2:0] BG_COL = 3'b000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_erase,
   input  logic [8*NREQ-1:0] req_old_x,
   input  logic [7*NREQ-1:0] req_old_y,
   input  logic [8*NREQ-1:0] req_new_x,
   input  logic [7*NREQ-1:0] req_new_y,
   input  logic [8*NREQ-1:0] req_size_x,
   input  logic [7*NREQ-1:0] req_size_y,
   input  logic [3*NREQ-1:0] req_colour,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [7:0]        vga_x,
   output logic [6:0]        vga_y,
   output logic [2:0]        vga_colour,
   output logic              vga_plot
);
   // state   | meaning
   // S_IDLE  | waiting for a request; grants and latches winner fields
   // S_ERASE | rastering old rect in BG_COL
   // S_DRAW  | rastering new rect in latched colour
   // S_DONE  | one-cycle done pulse to the served requester
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] win_q, win_d, arb_win;
   logic          arb_any, ld;

   logic [7:0] old_x_q, new_x_q, size_x_q;
   logic [6:0] old_y_q, new_y_q, size_y_q;
   logic [2:0] colour_q;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;

   logic [7:0] old_x_a  [NREQ];
   logic [6:0] old_y_a  [NREQ];
   logic [7:0] new_x_a  [NREQ];
   logic [6:0] new_y_a  [NREQ];
   logic [7:0] size_x_a [NREQ];
   logic [6:0] size_y_a [NREQ];
   logic [2:0] colour_a [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         old_x_a[i]  = req_old_x[8*i +: 8];
         old_y_a[i]  = req_old_y[7*i +: 7];
         new_x_a[i]  = req_new_x[8*i +: 8];
         new_y_a[i]  = req_new_y[7*i +: 7];
         size_x_a[i] = req_size_x[8*i +: 8];
         size_y_a[i] = req_size_y[7*i +: 7];
         colour_a[i] = req_colour[3*i +: 3];
      end
   end

   assign arb_any = |req;

`ifdef PLOT_RR_EN
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] rr_idx;

   // Scan from ptr+NREQ down to ptr+1 so the candidate nearest after ptr is written last.
   always_comb begin
      arb_win = '0;
      rr_idx  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         rr_idx = IW'((int'(ptr_q) + k) % NREQ);
         if (req[rr_idx]) arb_win = rr_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)  ptr_q <= IW'(NREQ - 1);
      else if (ld)  ptr_q <= arb_win;
   end
`else
   always_comb begin
      arb_win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i +: 1] != 1'b0) arb_win = IW'(i);
      end
   end
`endif

   logic [7:0] org_x;
   logic [6:0] org_y;
   logic [8:0] px;
   logic [7:0] py;
   logic       in_view, last_x, last_y, win_nonempty;

   assign org_x        = (state_q == S_ERASE) ? old_x_q : new_x_q;
   assign org_y        = (state_q == S_ERASE) ? old_y_q : new_y_q;
   assign px           = {1'b0, org_x} + {1'b0, cx_q};
   assign py           = {1'b0, org_y} + {1'b0, cy_q};
   assign in_view      = (px <= 9'(MAX_X)) && (py <= 8'(MAX_Y));
   assign last_x       = (cx_q == size_x_q - 8'd1);
   assign last_y       = (cy_q == size_y_q - 7'd1);
   assign win_nonempty = (size_x_a[arb_win] != 8'd0) && (size_y_a[arb_win] != 7'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         win_q    <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         old_x_q  <= '0;
         old_y_q  <= '0;
         new_x_q  <= '0;
         new_y_q  <= '0;
         size_x_q <= '0;
         size_y_q <= '0;
         colour_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         if (ld) begin
            old_x_q  <= old_x_a[arb_win];
            old_y_q  <= old_y_a[arb_win];
            new_x_q  <= new_x_a[arb_win];
            new_y_q  <= new_y_a[arb_win];
            size_x_q <= size_x_a[arb_win];
            size_y_q <= size_y_a[arb_win];
            colour_q <= colour_a[arb_win];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      ld         = 1'b0;
      grant      = '0;
      done       = '0;
      busy       = 1'b1;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            // Grant is combinational on req; hold it off while reset is asserted.
            if (resetn && arb_any) begin
               grant[arb_win] = 1'b1;
               ld             = 1'b1;
               win_d          = arb_win;
               cx_d           = '0;
               cy_d           = '0;
               if (!win_nonempty)           state_d = S_DONE;
               else if (req_erase[arb_win]) state_d = S_ERASE;
               else                         state_d = S_DRAW;
            end
         end
         S_ERASE, S_DRAW: begin
            vga_x      = px[7:0];
            vga_y      = py[6:0];
            vga_colour = (state_q == S_ERASE) ? BG_COL : colour_q;
            vga_plot   = in_view;
            if (!last_x) begin
               cx_d = cx_q + 8'd1;
            end else begin
               cx_d = '0;
               if (!last_y) begin
                  cy_d = cy_q + 7'd1;
               end else begin
                  cy_d    = '0;
                  state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
               end
            end
         end
         S_DONE: begin
            done[win_q] = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: directed jobs, mid-job reset, arbitration and random jobs
// checked against a raster-list model built from the rectangle rules.
`timescale 1ns/1ps
module tb_plot_scheduler;
   localparam int NREQ = 3;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NREQ-1:0]   req, req_erase;
   logic [8*NREQ-1:0] req_old_x, req_new_x, req_size_x;
   logic [7*NREQ-1:0] req_old_y, req_new_y, req_size_y;
   logic [3*NREQ-1:0] req_colour;
   logic [NREQ-1:0]   grant, done;
   logic              busy, vga_plot;
   logic [7:0]        vga_x;
   logic [6:0]        vga_y;
   logic [2:0]        vga_colour;

   int total = 0;
   int bad   = 0;
   int rr_last;
   int ex_q[$], ey_q[$], ec_q[$], ep_q[$];

   plot_scheduler dut (
      .clk(clk), .resetn(resetn), .req(req), .req_erase(req_erase),
      .req_old_x(req_old_x), .req_old_y(req_old_y), .req_new_x(req_new_x), .req_new_y(req_new_y),
      .req_size_x(req_size_x), .req_size_y(req_size_y), .req_colour(req_colour),
      .grant(grant), .done(done), .busy(busy),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input int r, input int erase, input int ox, input int oy,
                             input int nx, input int ny, input int sx, input int sy, input int col);
      req_erase[r]          = erase[0];
      req_old_x[8*r +: 8]   = 8'(ox);
      req_old_y[7*r +: 7]   = 7'(oy);
      req_new_x[8*r +: 8]   = 8'(nx);
      req_new_y[7*r +: 7]   = 7'(ny);
      req_size_x[8*r +: 8]  = 8'(sx);
      req_size_y[7*r +: 7]  = 7'(sy);
      req_colour[3*r +: 3]  = 3'(col);
   endtask

   // Expected pixels of one rectangle pass, raster order, x inner.
   task automatic build(input int ox, input int oy, input int sx, input int sy, input int col);
      for (int y = 0; y < sy; y++)
         for (int x = 0; x < sx; x++) begin
            ex_q.push_back(ox + x);
            ey_q.push_back(oy + y);
            ec_q.push_back(col);
            ep_q.push_back((ox + x <= 159 && oy + y <= 119) ? 1 : 0);
         end
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] mask);
      int w;
      w = -1;
`ifdef PLOT_RR_EN
      for (int k = 1; k <= NREQ; k++)
         if (w < 0 && mask[(rr_last + k) % NREQ]) w = (rr_last + k) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
         if (w < 0 && mask[i]) w = i;
`endif
      return w;
   endfunction

   // Called in the grant cycle (after #1); follows the job through to done.
   task automatic expect_job(input int r, input int erase, input int ox, input int oy,
                             input int nx, input int ny, input int sx, input int sy,
                             input int col, input int scramble);
      int n;
      chk("grant", 32'(grant), 1 << r);
      chk("busy_at_grant", 32'(busy), 0);
      rr_last = r;
      ex_q.delete(); ey_q.delete(); ec_q.delete(); ep_q.delete();
      if (erase != 0) build(ox, oy, sx, sy, 0);
      build(nx, ny, sx, sy, col);
      n = ep_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0 && scramble != 0)
            set_fields(r, 0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255),
                       $urandom_range(0, 127), $urandom_range(1, 9), $urandom_range(1, 9),
                       $urandom_range(0, 7));
         #1;
         chk("plot", 32'(vga_plot), ep_q[i]);
         if (ep_q[i] != 0) begin
            chk("x", 32'(vga_x), ex_q[i]);
            chk("y", 32'(vga_y), ey_q[i]);
            chk("colour", 32'(vga_colour), ec_q[i]);
         end
         chk("busy", 32'(busy), 1);
         chk("done_early", 32'(done), 0);
      end
      @(negedge clk); #1;
      chk("done", 32'(done), 1 << r);
      chk("plot_in_done", 32'(vga_plot), 0);
      req[r] = 1'b0;
      @(negedge clk); #1;
      chk("busy_after", 32'(busy), 0);
      chk("done_after", 32'(done), 0);
      chk("grant_after", 32'(grant), 0);
   endtask

   task automatic start_job(input int r, input int erase, input int ox, input int oy,
                            input int nx, input int ny, input int sx, input int sy,
                            input int col, input int scramble);
      @(negedge clk);
      set_fields(r, erase, ox, oy, nx, ny, sx, sy, col);
      req[r] = 1'b1;
      #1;
      expect_job(r, erase, ox, oy, nx, ny, sx, sy, col, scramble);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn  = 1'b1;
      rr_last = NREQ - 1;
   endtask

   initial begin
      logic [NREQ-1:0] mask;
      int w;
      resetn = 1'b0; req = '0; req_erase = '0;
      req_old_x = '0; req_old_y = '0; req_new_x = '0; req_new_y = '0;
      req_size_x = '0; req_size_y = '0; req_colour = '0;
      do_reset();
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_plot", 32'(vga_plot), 0);
      chk("rst_x", 32'(vga_x), 0);
      chk("rst_y", 32'(vga_y), 0);
      chk("rst_colour", 32'(vga_colour), 0);

      start_job(0, 1, 10, 20, 11, 21, 2, 2, 7, 0);
      start_job(1, 0, 0, 0, 150, 2, 16, 1, 5, 0);
      start_job(2, 1, 5, 5, 6, 6, 0, 3, 2, 0);
      start_job(2, 1, 30, 40, 31, 41, 3, 2, 4, 1);
      start_job(0, 1, 158, 118, 158, 118, 3, 3, 1, 0);
      start_job(1, 0, 0, 0, 250, 125, 10, 3, 3, 0);

      // Reset in the third erase pixel: job aborts, then is regranted in full.
      @(negedge clk);
      set_fields(0, 1, 10, 20, 11, 21, 2, 2, 7);
      req[0] = 1'b1;
      #1;
      chk("rstjob_grant", 32'(grant), 1);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk); #1;
      chk("rstjob_busy", 32'(busy), 0);
      chk("rstjob_plot", 32'(vga_plot), 0);
      chk("rstjob_done", 32'(done), 0);
      chk("rstjob_grant_held", 32'(grant), 0);
      resetn  = 1'b1;
      rr_last = NREQ - 1;
      #1;
      expect_job(0, 1, 10, 20, 11, 21, 2, 2, 7, 0);

      // Arbitration: 1x1 draw-only jobs, requests held across done.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_fields(i, 0, 0, 0, i * 10 + 1, 5, 1, 1, i + 1);
      for (int rnd = 0; rnd < 14; rnd++) begin
         @(negedge clk);
         mask = (rnd < 6) ? 3'b011 : 3'($urandom_range(1, 7));
         req  = mask;
         #1;
         w = model_winner(mask);
         chk("arb_grant", 32'(grant), 1 << w);
         rr_last = w;
         @(negedge clk); #1;
         chk("arb_plot", 32'(vga_plot), 1);
         chk("arb_x", 32'(vga_x), w * 10 + 1);
         chk("arb_colour", 32'(vga_colour), w + 1);
         @(negedge clk); #1;
         chk("arb_done", 32'(done), 1 << w);
      end
      @(negedge clk);
      req = '0;
      #1;
      chk("arb_idle", 32'(busy), 0);

      for (int j = 0; j < 25; j++)
         start_job($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 165),
                   $urandom_range(0, 127), $urandom_range(0, 165), $urandom_range(0, 127),
                   $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 7),
                   $urandom_range(0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
